// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared game states, screen constants and reset values for the flappy game
package flappy_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_FALL = 2'd2,
        GS_OVER = 2'd3
    } game_state_t;

    localparam int SCREEN_W_PX = 640;
    localparam int SCREEN_H_PX = 480;

    localparam logic [8:0] BIRD_RST  = 9'd232;
    localparam logic [8:0] HOLE_RST  = 9'd180;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci taps 8,6,5,4 (bit indices 7,5,4,3), shifting towards the MSB
    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/flappy_lfsr8.sv
// rtl/flappy_lfsr8.sv - free-running 8-bit LFSR used for hole placement
module flappy_lfsr8
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr8_next(value);
        end
    end

endmodule

// File: rtl/flappy_game_sequencer.sv
// rtl/flappy_game_sequencer.sv - per-frame bird physics, pipe scroll, scoring and game FSM; SPEEDUP_EN adds score-based speed
module flappy_game_sequencer
    import flappy_pkg::*;
#(
    parameter int BIRD_X     = 100,
    parameter int BIRD_SZ    = 8,
    parameter int PIPE_W     = 40,
    parameter int GAP        = 100,
    parameter int SCREEN_W   = SCREEN_W_PX,
    parameter int FLOOR_Y    = SCREEN_H_PX - 8,
    parameter int HOLE_MIN   = 40,
    parameter int PIPE_SPEED = 2,
    parameter int FLAP_VEL   = -8,
    parameter int MAX_FALL   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       flap,
    output logic [8:0] bird_pos,
    output logic [8:0] hole_pos,
    output logic [9:0] pipe_pos,
    output logic [7:0] score,
    output logic [1:0] game_state
);

    localparam logic signed [5:0]  FLAP_V     = 6'(FLAP_VEL);
    localparam logic signed [5:0]  MAX_FALL_V = 6'(MAX_FALL);
    localparam logic        [8:0]  FLOOR_V    = 9'(FLOOR_Y);
    localparam logic signed [10:0] FLOOR_S    = 11'(FLOOR_Y);
    localparam logic        [9:0]  SCREEN_W_V = 10'(SCREEN_W);
    localparam logic        [8:0]  HOLE_MIN_V = 9'(HOLE_MIN);
    localparam logic signed [11:0] PIPE_W_S   = 12'(PIPE_W);
    localparam logic signed [11:0] BIRD_X_S   = 12'(BIRD_X);
    localparam logic        [11:0] BIRD_X_U   = 12'(BIRD_X);
    localparam logic        [11:0] BIRD_SZ_U  = 12'(BIRD_SZ);
    localparam logic        [11:0] PIPE_W_U   = 12'(PIPE_W);
    localparam logic        [11:0] GAP_U      = 12'(GAP);

    game_state_t       state_q, state_d;
    logic signed [5:0] vel_q, vel_d;
    logic        [8:0] bird_d, hole_d;
    logic        [9:0] pipe_d;
    logic        [7:0] score_d;
    logic              vsync_q, flap_q, flap_pending;
    logic        [7:0] lfsr;

    logic              tick, flap_rise;
    logic        [9:0] speed;
    logic signed [5:0] vel_inc, vel_play;
    logic        [8:0] bird_play, bird_fall, hole_play;
    logic        [9:0] pipe_play;
    logic        [7:0] score_play;
    logic signed [11:0] old_x, new_x;
    logic        [11:0] px, by, hy;
    logic              respawn, crossing, x_ovl, y_hit, play_dead;

    assign tick       = vsync & ~vsync_q;
    assign flap_rise  = flap & ~flap_q;
    assign game_state = state_q;

    flappy_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr)
    );

    // Add a signed velocity to y in 11-bit signed space, then pin to [0, FLOOR_Y]
    function automatic logic [8:0] bird_step(input logic [8:0] y, input logic signed [5:0] v);
        logic signed [10:0] sum;
        sum = $signed({2'b00, y}) + $signed({{5{v[5]}}, v});
        if (sum[10]) begin
            return 9'd0;
        end else if (sum > FLOOR_S) begin
            return FLOOR_V;
        end else begin
            return sum[8:0];
        end
    endfunction

    always_comb begin
`ifdef SPEEDUP_EN
        speed = 10'(PIPE_SPEED) + ((score[7:3] > 5'd3) ? 10'd3 : {5'd0, score[7:3]});
`else
        speed = 10'(PIPE_SPEED);
`endif
        vel_inc   = (vel_q >= MAX_FALL_V) ? MAX_FALL_V : vel_q + 6'sd1;
        vel_play  = flap_pending ? FLAP_V : vel_inc;
        bird_play = bird_step(bird_pos, vel_play);
        bird_fall = bird_step(bird_pos, vel_inc);

        respawn   = pipe_pos < speed;
        pipe_play = respawn ? SCREEN_W_V : pipe_pos - speed;
        hole_play = respawn ? HOLE_MIN_V + {1'b0, lfsr} : hole_pos;

        // Crossing is judged on the unwrapped position so it still counts on a respawn tick
        old_x      = $signed({2'b00, pipe_pos});
        new_x      = old_x - $signed({2'b00, speed});
        crossing   = (old_x + PIPE_W_S >= BIRD_X_S) && (new_x + PIPE_W_S < BIRD_X_S);
        score_play = (crossing && score != 8'hFF) ? score + 8'd1 : score;

        px        = {2'b00, pipe_play};
        by        = {3'b000, bird_play};
        hy        = {3'b000, hole_play};
        x_ovl     = (BIRD_X_U + BIRD_SZ_U > px) && (BIRD_X_U < px + PIPE_W_U);
        y_hit     = (by < hy) || (by + BIRD_SZ_U > hy + GAP_U);
        play_dead = (x_ovl && y_hit) || (bird_play >= FLOOR_V);

        state_d = state_q;
        vel_d   = vel_q;
        bird_d  = bird_pos;
        pipe_d  = pipe_pos;
        hole_d  = hole_pos;
        score_d = score;

        if (tick) begin
            unique case (state_q)
                GS_IDLE, GS_PLAY: begin
                    if (state_q == GS_PLAY || flap_pending) begin
                        state_d = play_dead ? GS_FALL : GS_PLAY;
                        vel_d   = vel_play;
                        bird_d  = bird_play;
                        pipe_d  = pipe_play;
                        hole_d  = hole_play;
                        score_d = score_play;
                    end
                end
                GS_FALL: begin
                    vel_d  = vel_inc;
                    bird_d = bird_fall;
                    if (bird_fall == FLOOR_V) begin
                        state_d = GS_OVER;
                    end
                end
                GS_OVER: begin
                    if (flap_pending) begin
                        state_d = GS_IDLE;
                        vel_d   = 6'sd0;
                        bird_d  = BIRD_RST;
                        pipe_d  = 10'(SCREEN_W_PX);
                        hole_d  = HOLE_RST;
                        score_d = 8'd0;
                    end
                end
                default: state_d = GS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= GS_IDLE;
            vel_q        <= 6'sd0;
            bird_pos     <= BIRD_RST;
            pipe_pos     <= 10'(SCREEN_W_PX);
            hole_pos     <= HOLE_RST;
            score        <= 8'd0;
            vsync_q      <= 1'b0;
            flap_q       <= 1'b0;
            flap_pending <= 1'b0;
        end else begin
            vsync_q <= vsync;
            flap_q  <= flap;
            // Every tick consumes the pending flap; an edge on the tick cycle itself carries over
            if (tick) begin
                flap_pending <= flap_rise;
            end else if (flap_rise) begin
                flap_pending <= 1'b1;
            end
            state_q  <= state_d;
            vel_q    <= vel_d;
            bird_pos <= bird_d;
            pipe_pos <= pipe_d;
            hole_pos <= hole_d;
            score    <= score_d;
        end
    end

endmodule
